// File: rtl/shot_clock_pkg.sv
// Shared types and helpers for the shot clock timer.
// bin2bcd is only referenced when SHOT_CLOCK_BCD_EN is defined.
package shot_clock_pkg;

    typedef enum logic [1:0] {
        StStopped,
        StRun,
        StBuzz,
        StDone
    } state_e;

    localparam int unsigned FULL_VALUE_DEF  = 24;
    localparam int unsigned SHORT_VALUE_DEF = 14;

    // Two-digit BCD; values above 99 wrap modulo 100.
    function automatic logic [7:0] bin2bcd(input int unsigned value);
        int unsigned v;
        v = value % 100;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-cycle tick every TICK_DIV enabled cycles.
// The count is held while disabled, so a paused second resumes where it stopped.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned   CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shot_clock_timer.sv
// Basketball shot clock: per-second countdown with run/pause, full/short reloads
// and a timed buzzer pulse. Define SHOT_CLOCK_BCD_EN to add registered BCD outputs.
module shot_clock_timer
    import shot_clock_pkg::*;
#(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned FULL_VALUE  = FULL_VALUE_DEF,
    parameter int unsigned SHORT_VALUE = SHORT_VALUE_DEF,
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned BUZZ_CYCLES = 25000000
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic             reload_full,
    input  logic             reload_short,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             buzzer
`ifdef SHOT_CLOCK_BCD_EN
    ,
    output logic [3:0]       tens,
    output logic [3:0]       units
`endif
);

    localparam int unsigned BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [BW-1:0]    BUZZ_LAST = BW'(BUZZ_CYCLES - 1);
    localparam logic [WIDTH-1:0] FULL_CNT  = WIDTH'(FULL_VALUE);
    localparam logic [WIDTH-1:0] SHORT_CNT = WIDTH'(SHORT_VALUE);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic             r_expired, w_expired_nxt;
    logic             r_buzzer, w_buzzer_nxt;
    logic [BW-1:0]    r_buzz_cnt, w_buzz_cnt_nxt;

    logic w_reload;
    logic w_presc_en;
    logic w_tick;

    assign w_reload = reload_full | reload_short;
    // Pause and reload both suppress the prescaler step in their cycle.
    assign w_presc_en = (r_state == StRun) && !pause && !w_reload;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .i_clk   (clock_in),
        .i_rst_n (reset_n),
        .i_enable(w_presc_en),
        .i_clear (w_reload),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_expired_nxt  = r_expired;
        w_buzzer_nxt   = r_buzzer;
        w_buzz_cnt_nxt = r_buzz_cnt;

        if (w_reload) begin
            w_count_nxt    = reload_full ? FULL_CNT : SHORT_CNT;
            w_expired_nxt  = 1'b0;
            w_buzzer_nxt   = 1'b0;
            w_buzz_cnt_nxt = '0;
            w_state_nxt    = (r_state == StRun) ? StRun : StStopped;
        end else begin
            unique case (r_state)
                StStopped: begin
                    if (!pause && start && (r_count != '0)) begin
                        w_state_nxt = StRun;
                    end
                end
                StRun: begin
                    if (pause) begin
                        w_state_nxt = StStopped;
                    end else if (w_tick) begin
                        if (r_count > WIDTH'(1)) begin
                            w_count_nxt = r_count - 1'b1;
                        end else begin
                            w_count_nxt    = '0;
                            w_expired_nxt  = 1'b1;
                            w_buzzer_nxt   = 1'b1;
                            w_buzz_cnt_nxt = '0;
                            w_state_nxt    = StBuzz;
                        end
                    end
                end
                StBuzz: begin
                    if (r_buzz_cnt == BUZZ_LAST) begin
                        w_buzzer_nxt   = 1'b0;
                        w_buzz_cnt_nxt = '0;
                        w_state_nxt    = StDone;
                    end else begin
                        w_buzz_cnt_nxt = r_buzz_cnt + 1'b1;
                    end
                end
                StDone: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StStopped;
            r_count    <= FULL_CNT;
            r_expired  <= 1'b0;
            r_buzzer   <= 1'b0;
            r_buzz_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_expired  <= w_expired_nxt;
            r_buzzer   <= w_buzzer_nxt;
            r_buzz_cnt <= w_buzz_cnt_nxt;
        end
    end

    assign count   = r_count;
    assign running = (r_state == StRun);
    assign expired = r_expired;
    assign buzzer  = r_buzzer;

`ifdef SHOT_CLOCK_BCD_EN
    logic [7:0] r_bcd;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_bcd <= bin2bcd(FULL_VALUE);
        end else begin
            r_bcd <= bin2bcd(32'(w_count_nxt));
        end
    end

    assign tens  = r_bcd[7:4];
    assign units = r_bcd[3:0];
`endif

endmodule

// File: tb/tb_shot_clock_timer.sv
// Directed bench for shot_clock_timer with TICK_DIV=4, BUZZ_CYCLES=3, FULL=24, SHORT=14.
module tb_shot_clock_timer;

    logic       clock_in     = 1'b0;
    logic       reset_n      = 1'b0;
    logic       start        = 1'b0;
    logic       pause        = 1'b0;
    logic       reload_full  = 1'b0;
    logic       reload_short = 1'b0;
    logic [4:0] count;
    logic       running;
    logic       expired;
    logic       buzzer;
`ifdef SHOT_CLOCK_BCD_EN
    logic [3:0] tens;
    logic [3:0] units;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock_in = ~clock_in;

    shot_clock_timer #(
        .WIDTH      (5),
        .FULL_VALUE (24),
        .SHORT_VALUE(14),
        .TICK_DIV   (4),
        .BUZZ_CYCLES(3)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .start       (start),
        .pause       (pause),
        .reload_full (reload_full),
        .reload_short(reload_short),
        .count       (count),
        .running     (running),
        .expired     (expired),
`ifdef SHOT_CLOCK_BCD_EN
        .tens        (tens),
        .units       (units),
`endif
        .buzzer      (buzzer)
    );

    typedef struct {
        logic s;
        logic p;
        logic rf;
        logic rs;
        int   exp_count;
        logic exp_running;
        logic exp_expired;
        logic exp_buzzer;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs for exactly one rising edge, then sample 1 ns after it.
    task automatic cyc(input logic s, input logic p, input logic rf, input logic rs);
        start        = s;
        pause        = p;
        reload_full  = rf;
        reload_short = rs;
        @(posedge clock_in);
        #1;
        start        = 1'b0;
        pause        = 1'b0;
        reload_full  = 1'b0;
        reload_short = 1'b0;
    endtask

    task automatic wait_count(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (int'(count) == target) break;
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk(name, int'(count), target);
    endtask

    task automatic wait_buzz(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (buzzer) break;
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk(name, int'(buzzer), 1);
    endtask

    initial begin
        // start, then one decrement every 4 cycles, then a pause 2 cycles into a second
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 23, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 23, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 23, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 23, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 22, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 22, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 22, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 22, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clock_in);
        #1;
        chk("reset count", int'(count), 24);
        chk("reset running", int'(running), 0);
        chk("reset expired", int'(expired), 0);
        chk("reset buzzer", int'(buzzer), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].s, vecs[i].p, vecs[i].rf, vecs[i].rs);
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d running", i), int'(running), int'(vecs[i].exp_running));
            chk($sformatf("vec%0d expired", i), int'(expired), int'(vecs[i].exp_expired));
            chk($sformatf("vec%0d buzzer", i), int'(buzzer), int'(vecs[i].exp_buzzer));
        end

        // Paused: count frozen for 20 cycles
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            chk("pause hold count", int'(count), 22);
            chk("pause hold running", int'(running), 0);
        end

        // Resume completes the partial second: decrement 2 cycles into RUN
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume running", int'(running), 1);
        chk("resume count e0", int'(count), 22);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume count e1", int'(count), 22);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume count e2", int'(count), 21);

        // reload_short colliding with a tick at count=5
        wait_count(5, 100, "reach count 5");
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre-reload count", int'(count), 5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("short reload count", int'(count), 14);
        chk("short reload running", int'(running), 1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("after reload 3 cyc", int'(count), 14);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("after reload 4 cyc", int'(count), 13);

        // Run to expiry and the buzzer pulse
        wait_count(1, 60, "reach count 1");
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("count 1 held", int'(count), 1);
        chk("no early buzz", int'(buzzer), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("expiry count", int'(count), 0);
        chk("expiry expired", int'(expired), 1);
        chk("expiry buzzer", int'(buzzer), 1);
        chk("expiry running", int'(running), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("buzz cyc2", int'(buzzer), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("buzz cyc3", int'(buzzer), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("buzz end", int'(buzzer), 0);
        chk("done expired", int'(expired), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("done start ignored running", int'(running), 0);
        chk("done start ignored count", int'(count), 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("done count stays 0", int'(count), 0);
        chk("done expired held", int'(expired), 1);

        // Reload out of DONE, then both reloads during BUZZ
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("done reload count", int'(count), 24);
        chk("done reload expired", int'(expired), 0);
        chk("done reload running", int'(running), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart running", int'(running), 1);
        wait_buzz(120, "reach buzz 2");
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("buzz reload count", int'(count), 24);
        chk("buzz reload buzzer", int'(buzzer), 0);
        chk("buzz reload expired", int'(expired), 0);
        chk("buzz reload running", int'(running), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stopped count held", int'(count), 24);
        chk("stopped buzzer low", int'(buzzer), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("stopped start running", int'(running), 1);

        // Async reset during BUZZ
        wait_buzz(120, "reach buzz 3");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst buzzer", int'(buzzer), 0);
        chk("async rst count", int'(count), 24);
        chk("async rst running", int'(running), 0);
        chk("async rst expired", int'(expired), 0);
`ifdef SHOT_CLOCK_BCD_EN
        chk("async rst tens", int'(tens), 2);
        chk("async rst units", int'(units), 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
